// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
// Optional digit blanking is enabled by defining BCD_SCHED_BLANK_EN.
package bcd_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int BIN_W_DEF = 8;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_scheduler_if.sv
// Request/result bus between requesters (master) and the shared converter (slave).
interface bcd_scheduler_if #(
  parameter int NREQ  = bcd_pkg::NREQ_DEF,
  parameter int BIN_W = bcd_pkg::BIN_W_DEF
);
  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] bin_flat;
  logic [NREQ-1:0]       ack;
  logic                  out_valid;
  logic [1:0]            out_id;
  logic [3:0]            hundreds;
  logic [3:0]            tens;
  logic [3:0]            ones;
  logic                  busy;

  modport master (output req, bin_flat,
                  input  ack, out_valid, out_id, hundreds, tens, ones, busy);
  modport slave  (input  req, bin_flat,
                  output ack, out_valid, out_id, hundreds, tens, ones, busy);
endinterface

// File: rtl/bcd_serial.sv
// Serial shift-add-3 binary-to-BCD engine, one operand bit per cycle, MSB first.
module bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] operand,
  output logic             done,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);
  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] sr_q, sr_d, sr_n_s;
  logic [11:0]      bcd_q, bcd_d, bcd_n_s, adj_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // One shift step; digit outputs show the post-step value so the final
  // shift and the caller's capture happen on the same edge.
  always_comb begin
    adj_s             = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    {bcd_n_s, sr_n_s} = {adj_s, sr_q} << 1;
    done              = active_q && (cnt_q == CNT_W'(BIN_W - 1));
    hundreds          = bcd_n_s[11:8];
    tens              = bcd_n_s[7:4];
    ones              = bcd_n_s[3:0];
  end

  always_comb begin
    sr_d     = sr_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      sr_d     = operand;
      bcd_d    = 12'd0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      sr_d     = sr_n_s;
      bcd_d    = bcd_n_s;
      cnt_d    = cnt_q + CNT_W'(1);
      active_d = !done;
    end else begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q     <= '0;
      bcd_q    <= 12'd0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/bcd_scheduler.sv
// Round-robin arbiter and FSM sharing one serial BCD converter among NREQ requesters.
// Define BCD_SCHED_BLANK_EN to blank leading zero digits to 4'hF.
module bcd_scheduler
  import bcd_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  bcd_scheduler_if.slave  bus
);
  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d, last_q, last_d, id_q, id_d, pick_s;
  logic             pick_valid_s;
  logic [3:0]       req_ext_s;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             valid_q, valid_d, busy_q, busy_d;
  logic [3:0]       hun_q, hun_d, ten_q, ten_d, one_q, one_d;
  logic             eng_start_s, eng_done_s;
  logic [BIN_W-1:0] eng_operand_s;
  logic [3:0]       eng_h_s, eng_t_s, eng_o_s;

  bcd_serial #(.BIN_W(BIN_W)) u_serial (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start_s),
    .operand  (eng_operand_s),
    .done     (eng_done_s),
    .hundreds (eng_h_s),
    .tens     (eng_t_s),
    .ones     (eng_o_s)
  );

  // Descending scan so the smallest offset from last_q wins.
  always_comb begin
    req_ext_s    = 4'(bus.req);
    pick_s       = last_q;
    pick_valid_s = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_ext_s[2'((int'(last_q) + i) % NREQ)]) begin
        pick_s       = 2'((int'(last_q) + i) % NREQ);
        pick_valid_s = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    id_d          = id_q;
    ack_d         = '0;
    valid_d       = 1'b0;
    hun_d         = hun_q;
    ten_d         = ten_q;
    one_d         = one_q;
    eng_start_s   = 1'b0;
    eng_operand_s = BIN_W'(bus.bin_flat >> (int'(grant_q) * BIN_W));
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_d = pick_s;
          last_d  = pick_s;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        eng_start_s = 1'b1;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (eng_done_s) begin
          state_d = ST_DONE;
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
          valid_d = 1'b1;
          id_d    = grant_q;
`ifdef BCD_SCHED_BLANK_EN
          hun_d   = (eng_h_s == 4'd0) ? BLANK : eng_h_s;
          ten_d   = ((eng_h_s == 4'd0) && (eng_t_s == 4'd0)) ? BLANK : eng_t_s;
`else
          hun_d   = eng_h_s;
          ten_d   = eng_t_s;
`endif
          one_d   = eng_o_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'(NREQ - 1);
      id_q    <= 2'd0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      hun_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      id_q    <= id_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_id    = id_q;
  assign bus.hundreds  = hun_q;
  assign bus.tens      = ten_q;
  assign bus.ones      = one_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bcd_scheduler.sv
// Self-checking bench for bcd_scheduler against a decimal/round-robin reference model.
module tb_bcd_scheduler;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   m_last;

  bcd_scheduler_if #(.NREQ(3), .BIN_W(8)) bus ();

  bcd_scheduler #(.NREQ(3), .BIN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] exp_bcd(input int n);
    int h, t, o;
    h = n / 100;
    t = (n / 10) % 10;
    o = n % 10;
`ifdef BCD_SCHED_BLANK_EN
    if (h == 0) h = 15;
    if (n < 10) t = 15;
`endif
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  function automatic int rr(input logic [2:0] r, input int last);
    for (int off = 1; off <= 3; off++) begin
      if (r[(last + off) % 3]) return (last + off) % 3;
    end
    return last;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int k, input logic [7:0] v);
    bus.bin_flat[k*8 +: 8] = v;
  endtask

  task automatic wait_ack(output int cycles, output logic seen);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      cycles = i;
      if (bus.ack !== 3'b000) seen = 1'b1;
    end
  endtask

  task automatic rst_dut();
    rst      = 1'b0;
    bus.req  = 3'b000;
    tick();
    tick();
    rst      = 1'b1;
    m_last   = 2;
  endtask

  task automatic check_result(input string name, input logic seen, input int exp_id,
                              input int exp_val);
    logic [11:0] got;
    got = {bus.hundreds, bus.tens, bus.ones};
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s ack timeout: got ack=%b, required an ack pulse", name, bus.ack);
    end else if (bus.ack !== (3'b001 << exp_id) || bus.out_valid !== 1'b1 ||
                 bus.out_id !== 2'(exp_id) || got !== exp_bcd(exp_val)) begin
      failures++;
      $display("FAIL %s: got ack=%b valid=%b id=%0d digits=%h, required ack=%b valid=1 id=%0d digits=%h",
               name, bus.ack, bus.out_valid, bus.out_id, got, 3'b001 << exp_id, exp_id,
               exp_bcd(exp_val));
    end
  endtask

  task automatic test_reset();
    bus.bin_flat = '0;
    rst_dut();
    tick();
    checks++;
    if (bus.ack !== 3'b000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_id !== 2'd0 || {bus.hundreds, bus.tens, bus.ones} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: got ack=%b valid=%b busy=%b id=%0d digits=%h, required all zero",
               bus.ack, bus.out_valid, bus.busy, bus.out_id, {bus.hundreds, bus.tens, bus.ones});
    end
  endtask

  task automatic test_single();
    int cyc; logic seen;
    rst_dut();
    set_bin(0, 8'd173);
    bus.req = 3'b001;
    wait_ack(cyc, seen);
    bus.req = 3'b000;
    check_result("single_173", seen, 0, 173);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles, required 10", cyc);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_done: got %b, required 1", bus.busy);
    end
    tick();
    tick();
    checks++;
    if (bus.ack !== 3'b000 || bus.out_valid !== 1'b0 ||
        {bus.hundreds, bus.tens, bus.ones} !== exp_bcd(173) || bus.out_id !== 2'd0) begin
      failures++;
      $display("FAIL hold_after_done: got ack=%b valid=%b digits=%h id=%0d, required 000/0/%h/0",
               bus.ack, bus.out_valid, {bus.hundreds, bus.tens, bus.ones}, bus.out_id,
               exp_bcd(173));
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic seen;
    int vals[3] = '{12, 59, 200};
    rst_dut();
    for (int k = 0; k < 3; k++) set_bin(k, 8'(vals[k]));
    bus.req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      int exp_id;
      exp_id = rr(bus.req, m_last);
      m_last = exp_id;
      wait_ack(cyc, seen);
      check_result("contention", seen, exp_id, vals[exp_id]);
      checks++;
      if (cyc !== ((k == 0) ? 10 : 11)) begin
        failures++;
        $display("FAIL contention_gap%0d: got %0d cycles, required %0d", k, cyc,
                 (k == 0) ? 10 : 11);
      end
      bus.req[exp_id] = 1'b0;
    end
  endtask

  task automatic test_operand_change();
    int cyc; logic seen;
    rst_dut();
    set_bin(0, 8'd10);
    bus.req = 3'b001;
    repeat (4) tick();
    set_bin(0, 8'd99);
    wait_ack(cyc, seen);
    bus.req = 3'b000;
    check_result("operand_change", seen, 0, 10);
  endtask

  task automatic test_drop_req();
    int cyc; logic seen;
    rst_dut();
    set_bin(1, 8'd77);
    bus.req = 3'b010;
    tick();
    tick();
    bus.req = 3'b000;
    wait_ack(cyc, seen);
    check_result("drop_after_grant", seen, 1, 77);
  endtask

  task automatic test_reset_mid();
    int cyc; logic seen; logic any_ack;
    rst_dut();
    set_bin(0, 8'd123);
    bus.req = 3'b001;
    repeat (5) tick();
    rst     = 1'b0;
    bus.req = 3'b000;
    #1;
    checks++;
    if (bus.ack !== 3'b000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        {bus.hundreds, bus.tens, bus.ones} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset_mid: got ack=%b valid=%b busy=%b digits=%h, required zeros",
               bus.ack, bus.out_valid, bus.busy, {bus.hundreds, bus.tens, bus.ones});
    end
    tick();
    rst     = 1'b1;
    m_last  = 2;
    any_ack = 1'b0;
    repeat (12) begin
      tick();
      if (bus.ack !== 3'b000) any_ack = 1'b1;
    end
    checks++;
    if (any_ack) begin
      failures++;
      $display("FAIL no_ack_after_reset: got an ack, required none");
    end
    set_bin(1, 8'd45);
    bus.req = 3'b010;
    wait_ack(cyc, seen);
    bus.req = 3'b000;
    check_result("post_reset_req1", seen, 1, 45);
    checks++;
    if (cyc !== 10) begin
      failures++;
      $display("FAIL post_reset_latency: got %0d cycles, required 10", cyc);
    end
  endtask

  task automatic test_boundary();
    int cyc; logic seen;
    int vals[4] = '{255, 0, 7, 40};
    rst_dut();
    for (int i = 0; i < 4; i++) begin
      set_bin(2, 8'(vals[i]));
      bus.req = 3'b100;
      wait_ack(cyc, seen);
      bus.req = 3'b000;
      check_result("boundary", seen, 2, vals[i]);
      tick();
    end
  endtask

  task automatic test_random();
    int cyc; logic seen; int exp_id;
    logic [2:0] r, newbits;
    logic [7:0] opnd[3];
    rst_dut();
    r = 3'b000;
    for (int it = 0; it < 24; it++) begin
      if (r == 3'b000 || $urandom_range(0, 1) == 1) begin
        newbits = 3'($urandom_range(1, 7)) & ~r;
        for (int k = 0; k < 3; k++) begin
          if (newbits[k]) begin
            opnd[k] = 8'($urandom_range(0, 255));
            set_bin(k, opnd[k]);
          end
        end
        r = r | newbits;
      end
      bus.req = r;
      exp_id  = rr(r, m_last);
      m_last  = exp_id;
      wait_ack(cyc, seen);
      check_result("random", seen, exp_id, int'(opnd[exp_id]));
      if ($urandom_range(0, 3) != 0) r[exp_id] = 1'b0;
      bus.req = r;
    end
    bus.req = 3'b000;
    repeat (12) tick();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_last       = 2;
    rst          = 1'b0;
    bus.req      = 3'b000;
    bus.bin_flat = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_operand_change();
    test_drop_req();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scheduler.md
BCD_SCHEDULER -- requirements
Module: bcd_scheduler

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of requesters sharing the converter; legal range 2..4.
REQ-002 Parameter BIN_W, default 8, SHALL set the binary operand width; output digit widths are fixed for BIN_W=8.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry per-requester conversion requests, held high until the matching ack.
REQ-006 bin_flat  input  NREQ*BIN_W  SHALL carry the operands; requester k occupies bits [k*BIN_W +: BIN_W].
REQ-007 ack  output  NREQ  SHALL pulse one cycle, one-hot, when requester k's result is presented.
REQ-008 out_valid  output  1  SHALL pulse one cycle, coincident with ack.
REQ-009 out_id  output  2  SHALL give the index of the requester owning the current result.
REQ-010 hundreds, tens, ones  output  4 each  SHALL carry the BCD result digits.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE, encoded through the shared package.
REQ-013 IDLE: if any req bit is high, the next cycle SHALL be LOAD, with grant chosen round-robin starting at (last_grant+1) mod NREQ.
REQ-014 LOAD: the granted operand SHALL be captured in one cycle; later operand changes SHALL be ignored.
REQ-015 SHIFT: exactly BIN_W cycles of shift-add-3, one bit per cycle, MSB first; add-3 applied to each digit >=5 before the shift.
REQ-016 DONE: one cycle; digits, out_id and out_valid/ack SHALL update; next state SHALL be IDLE.
REQ-017 Latency SHALL be 10 cycles from the IDLE cycle that sampled req to the ack pulse (BIN_W=8); throughput 1 conversion per 11 cycles.
REQ-018 hundreds, tens, ones, out_id SHALL hold their values between DONE cycles.
REQ-019 A requester dropping req after grant SHALL NOT abort; its conversion completes and ack still pulses.
REQ-020 A requester keeping req high through ack SHALL be treated as a new request and re-arbitrated.
REQ-021 Simultaneous requests SHALL be served in round-robin order with no requester starved beyond NREQ-1 conversions.
REQ-022 Operand 255 SHALL yield 2/5/5; operand 0 SHALL yield 0/0/0 (absent blanking).

Reset
REQ-023 On rst low, state SHALL go to IDLE, last_grant to NREQ-1 (so requester 0 wins first), all outputs to 0, immediately and asynchronously.
REQ-024 Reset asserted mid-conversion SHALL discard the conversion with no ack issued.

Configuration
REQ-025 With BCD_SCHED_BLANK_EN defined, a zero hundreds digit SHALL output 4'hF, and tens SHALL output 4'hF when both hundreds and tens are zero; ones is never blanked.
REQ-026 Without BCD_SCHED_BLANK_EN, raw digits SHALL be output unchanged.

Structure
REQ-027 Package bcd_pkg SHALL hold the FSM state typedef, the BLANK digit constant 4'hF, and the default NREQ/BIN_W constants.
REQ-028 The shift-add-3 engine SHALL be a sub-module bcd_serial (start, done, operand in, three digits out); bcd_scheduler owns arbitration, FSM and output registers.

Verification
REQ-029 Single request: req=001, bin0=8'd173 -> ack=001 exactly 10 cycles later, out_id=0, digits 1/7/3.
REQ-030 Contention: req=111 held, bins 12/59/200 -> acks in order 0,1,2, digits 0/1/2, 0/5/9, 2/0/0, 11 cycles apart.
REQ-031 Operand change: bin0 changes 8'd10->8'd99 during SHIFT -> result 0/1/0.
REQ-032 Reset mid-SHIFT: rst low at cycle 5 -> no ack, outputs 0, busy 0; next req=010 served first-come.
REQ-033 Blanking (macro on): bin=8'd7 -> hundreds 4'hF, tens 4'hF, ones 7; bin=8'd40 -> F/4/0; macro off -> 0/0/7.
REQ-034 Boundary: bin=8'd255 -> 2/5/5; bin=8'd0 -> 0/0/0 (F/F/0 with macro).
